// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron_layer design:
//   state_e     - sequencing states of the layer controller
//   sel_width   - width of a select field able to address n items (min 1 bit)
//   acc_width   - accumulator width that cannot overflow for n products
//   frac_bits   - number of fractional bits of the fixed-point format
//   sat_signed  - clamp a wide signed value into a w-bit signed range
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ACT   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-precision product is 2*dw bits; summing n of them needs clog2(n)
    // more, plus one bit of headroom for the bias term.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    function automatic int frac_bits(input int dw, input int iw);
        return dw - iw;
    endfunction

    function automatic longint sat_signed(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/neuron_layer_if.sv
// -----------------------------------------------------------------------------
// neuron_layer_if
// Bundles the streaming input, configuration and result handshake of the
// neuron layer.
//   in_data/in_valid/in_ready    - input element stream (signed elements)
//   cfg_we/cfg_bias_we           - weight / bias write strobes
//   cfg_neuron/cfg_addr/cfg_data - target neuron, weight index, value
//   out_data/out_valid/out_ready - packed result vector and its handshake
// master drives stimulus/config and consumes results; slave is the layer.
// -----------------------------------------------------------------------------
interface neuron_layer_if
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 16,
    parameter int DATA_WIDTH  = 8
) ();

    localparam int NSEL_W = sel_width(NUM_NEURONS);
    localparam int ASEL_W = sel_width(NUM_INPUTS);

    logic signed [DATA_WIDTH-1:0]         in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic                                 cfg_we;
    logic                                 cfg_bias_we;
    logic [NSEL_W-1:0]                    cfg_neuron;
    logic [ASEL_W-1:0]                    cfg_addr;
    logic signed [DATA_WIDTH-1:0]         cfg_data;
    logic [NUM_NEURONS*DATA_WIDTH-1:0]    out_data;
    logic                                 out_valid;
    logic                                 out_ready;

    modport master (
        output in_data, in_valid, cfg_we, cfg_bias_we, cfg_neuron, cfg_addr,
               cfg_data, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, cfg_we, cfg_bias_we, cfg_neuron, cfg_addr,
               cfg_data, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// One neuron lane: weight store, bias, registered product, accumulator and
// output activation stage.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   accept_i       - an input element is accepted this cycle
//   acc_en_i       - add the registered product into the accumulator
//   act_en_i       - compute and register the activated output
//   clear_i        - clear the accumulator (result consumed)
//   in_data_i      - input element, idx_i selects the matching weight
//   w_we_i/b_we_i  - weight / bias write enables (already qualified)
//   w_addr_i       - weight index for writes, cfg_data_i the value
//   out_o          - registered activated output
// Build option: define NN_RELU_EN for a ReLU activation; otherwise the
// saturated value is passed through unchanged.
// -----------------------------------------------------------------------------
module neuron_mac
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 8,
    parameter int INT_WIDTH  = 4,
    parameter int CNT_W      = sel_width(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         accept_i,
    input  logic                         acc_en_i,
    input  logic                         act_en_i,
    input  logic                         clear_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic [CNT_W-1:0]             idx_i,
    input  logic                         w_we_i,
    input  logic [CNT_W-1:0]             w_addr_i,
    input  logic                         b_we_i,
    input  logic signed [DATA_WIDTH-1:0] cfg_data_i,
    output logic signed [DATA_WIDTH-1:0] out_o
);

    localparam int ACC_W  = acc_width(DATA_WIDTH, NUM_INPUTS);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int FRAC   = frac_bits(DATA_WIDTH, INT_WIDTH);

    logic signed [DATA_WIDTH-1:0] weight_mem [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] bias_q;

    logic signed [PROD_W-1:0]     product_q, product_d;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [DATA_WIDTH-1:0] out_q;

    logic signed [DATA_WIDTH-1:0] weight_sel;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      bias_ext;
    logic signed [ACC_W-1:0]      biased;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic signed [DATA_WIDTH-1:0] act_d;

    // Weights and bias live outside the reset domain so a reset only aborts
    // the vector in flight and keeps the programmed coefficients.
    always_ff @(posedge clk) begin
        if (w_we_i) begin
            weight_mem[w_addr_i] <= cfg_data_i;
        end
        if (b_we_i) begin
            bias_q <= cfg_data_i;
        end
    end

    assign weight_sel = weight_mem[idx_i];

    // Product is zero on cycles without an accepted element, so the
    // accumulator can add it unconditionally while enabled.
    always_comb begin
        product_d = '0;
        if (accept_i) begin
            product_d = in_data_i * weight_sel;
        end
    end

    assign prod_ext = {{(ACC_W-PROD_W){product_q[PROD_W-1]}}, product_q};
    assign bias_ext = {{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

    // Bias is aligned to the product scale (2*FRAC fractional bits) before
    // the sum is rescaled; >>> on a signed value rounds toward -inf.
    always_comb begin
        biased  = acc_q + (bias_ext <<< FRAC);
        shifted = biased >>> FRAC;
        sat_val = DATA_WIDTH'(sat_signed(longint'(shifted), DATA_WIDTH));
`ifdef NN_RELU_EN
        act_d = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
        act_d = sat_val;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            product_q <= '0;
            acc_q     <= '0;
            out_q     <= '0;
        end else begin
            product_q <= product_d;
            if (clear_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_q + prod_ext;
            end
            if (act_en_i) begin
                out_q <= act_d;
            end
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/neuron_layer.sv
// -----------------------------------------------------------------------------
// neuron_layer
// NUM_NEURONS parallel fixed-point neurons fed by one shared input stream.
// Each accepted element k is multiplied by weight[n][k] in every lane; after
// NUM_INPUTS elements the sums are biased, rescaled, saturated, activated and
// presented as one packed result vector held until the consumer accepts it.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset (aborts the current vector,
//            coefficients are kept)
//   bus    - neuron_layer_if.slave: input stream, configuration port and
//            result handshake
// Build option: NN_RELU_EN selects a ReLU activation (default: identity).
// Sequencing: IDLE -> ACCUM -> DRAIN -> ACT -> DONE -> IDLE. Coefficient
// writes are honoured only in IDLE.
// -----------------------------------------------------------------------------
module neuron_layer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int INT_WIDTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    neuron_layer_if.slave bus
);

    localparam int              CNT_W    = sel_width(NUM_INPUTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept;
    logic acc_en;
    logic act_en;
    logic clear_en;
    logic cfg_open;
    logic in_ready_c;
    logic out_valid_c;
    logic addr_ok;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        accept      = 1'b0;
        acc_en      = 1'b0;
        act_en      = 1'b0;
        clear_en    = 1'b0;
        cfg_open    = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                in_ready_c = 1'b1;
                acc_en     = 1'b1;
                cfg_open   = (state_q == ST_IDLE);
                accept     = bus.in_valid;
                if (bus.in_valid) begin
                    // With a single input the first element is also the last,
                    // which takes IDLE straight to DRAIN.
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        count_d = '0;
                    end else begin
                        state_d = ST_ACCUM;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                acc_en  = 1'b1;
                state_d = ST_ACT;
            end
            ST_ACT: begin
                act_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    clear_en = 1'b1;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;

    // Index range check matters only when NUM_INPUTS is not a power of two.
    assign addr_ok = (int'(bus.cfg_addr) < NUM_INPUTS);

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
        logic                         lane_sel;
        logic                         w_we;
        logic                         b_we;
        logic signed [DATA_WIDTH-1:0] lane_out;

        assign lane_sel = cfg_open && (int'(bus.cfg_neuron) == gi);
        assign w_we     = lane_sel && bus.cfg_we && addr_ok;
        assign b_we     = lane_sel && bus.cfg_bias_we;

        neuron_mac #(
            .NUM_INPUTS (NUM_INPUTS),
            .DATA_WIDTH (DATA_WIDTH),
            .INT_WIDTH  (INT_WIDTH),
            .CNT_W      (CNT_W)
        ) u_mac (
            .clk        (clk),
            .reset      (reset),
            .accept_i   (accept),
            .acc_en_i   (acc_en),
            .act_en_i   (act_en),
            .clear_i    (clear_en),
            .in_data_i  (bus.in_data),
            .idx_i      (count_q),
            .w_we_i     (w_we),
            .w_addr_i   (bus.cfg_addr),
            .b_we_i     (b_we),
            .cfg_data_i (bus.cfg_data),
            .out_o      (lane_out)
        );

        assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_out;
    end

endmodule

// File: tb/tb_neuron_layer.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer
// Directed and randomized stimulus for neuron_layer (4 neurons, 4 inputs,
// Q4.4 data). Expected lane values come from an arithmetic reference model:
// dot product plus scaled bias, floor rescale, clamp, optional ReLU.
// -----------------------------------------------------------------------------
module tb_neuron_layer;

    localparam int NN   = 4;
    localparam int NI   = 4;
    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int FRAC = DW - IW;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    neuron_layer_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

    neuron_layer #(
        .NUM_NEURONS (NN),
        .NUM_INPUTS  (NI),
        .DATA_WIDTH  (DW),
        .INT_WIDTH   (IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int w_m [NN][NI];
    int b_m [NN];
    int x_v [NI];
    int exp_lane [NN];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on real-valued fixed-point numbers.
    function automatic int ref_lane(input int n);
        longint acc;
        acc = 0;
        for (int k = 0; k < NI; k++) begin
            acc += longint'(x_v[k]) * longint'(w_m[n][k]);
        end
        acc += longint'(b_m[n]) * (longint'(1) << FRAC);
        acc = acc >>> FRAC;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
`ifdef NN_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return int'(acc);
    endfunction

    task automatic cfg_write(input int n, input int k, input int val, input bit we, input bit bwe);
        bus.cfg_neuron  = 2'(n);
        bus.cfg_addr    = 2'(k);
        bus.cfg_data    = 8'(val);
        bus.cfg_we      = we;
        bus.cfg_bias_we = bwe;
        tick();
        bus.cfg_we      = 1'b0;
        bus.cfg_bias_we = 1'b0;
        if (we)  w_m[n][k] = val;
        if (bwe) b_m[n]    = val;
    endtask

    task automatic set_weights(input int val);
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++)
                cfg_write(n, k, val, 1'b1, 1'b0);
    endtask

    task automatic set_biases(input int val);
        for (int n = 0; n < NN; n++)
            cfg_write(n, 0, val, 1'b0, 1'b1);
    endtask

    task automatic offer_element(input int val);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(val);
        while (bus.in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check_eq("accept_timeout", 64'(w), 64'(0));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_vector(input int gap_max);
        for (int k = 0; k < NI; k++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            offer_element(x_v[k]);
        end
        check_eq("drain_in_ready", 64'(bus.in_ready), 64'(0));
    endtask

    task automatic expect_result(input string tag, input int hold);
        int lat;
        logic [NN*DW-1:0] snap;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(2));
        for (int n = 0; n < NN; n++)
            check_eq($sformatf("%s_lane%0d", tag, n), 64'(bus.out_data[n*DW +: DW]),
                     64'(exp_lane[n] & 255));
        snap = bus.out_data;
        for (int c = 0; c < hold; c++) begin
            tick();
            check_eq({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
            check_eq({tag, "_hold_data"}, 64'(bus.out_data), 64'(snap));
            check_eq({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_release_valid"}, 64'(bus.out_valid), 64'(0));
        check_eq({tag, "_release_in_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic fill_x(input int val);
        for (int k = 0; k < NI; k++) x_v[k] = val;
    endtask

    task automatic fill_exp(input int val);
        for (int n = 0; n < NN; n++) exp_lane[n] = val;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_bias_we = 1'b0;
        bus.cfg_neuron  = '0;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
        bus.out_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_out_data", 64'(bus.out_data), 64'(0));
        reset = 1'b1;
        tick();
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // 1.0 weights, 1.0 inputs -> 4.0
        set_weights(16);
        set_biases(0);
        fill_x(16);
        send_vector(0);
        fill_exp(8'h40);
        expect_result("unity", 0);

        // -1.0 weights -> -4.0, clamped to 0 with ReLU
        set_weights(-16);
        send_vector(1);
`ifdef NN_RELU_EN
        fill_exp(8'h00);
`else
        fill_exp(8'hC0);
`endif
        expect_result("negative", 0);

        // 7.0 * 7.0 * 4 overflows -> positive saturation
        set_weights(112);
        fill_x(112);
        send_vector(0);
        fill_exp(8'h7F);
        expect_result("sat_pos", 0);

        // Bias on lane 2 only, result held under back-pressure
        set_weights(16);
        cfg_write(2, 0, 16, 1'b0, 1'b1);
        fill_x(16);
        send_vector(0);
        fill_exp(8'h40);
        exp_lane[2] = 8'h50;
        expect_result("bias_hold", 5);

        // Reset after two elements aborts the vector, coefficients survive
        cfg_write(2, 0, 0, 1'b0, 1'b1);
        offer_element(16);
        offer_element(16);
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("midrst_out_data", 64'(bus.out_data), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        send_vector(0);
        fill_exp(8'h40);
        expect_result("after_reset", 0);

        // Weight write attempted while accumulating must be ignored
        offer_element(16);
        bus.cfg_neuron = 2'd0;
        bus.cfg_addr   = 2'd3;
        bus.cfg_data   = 8'h00;
        bus.cfg_we     = 1'b1;
        for (int k = 1; k < NI; k++) offer_element(16);
        bus.cfg_we = 1'b0;
        check_eq("cfgaccum_in_ready", 64'(bus.in_ready), 64'(0));
        fill_exp(8'h40);
        expect_result("cfg_accum", 0);

        // Randomized vectors against the reference model
        for (int v = 0; v < 12; v++) begin
            if (v % 3 == 0) begin
                for (int n = 0; n < NN; n++) begin
                    for (int k = 0; k < NI; k++) begin
                        int wv;
                        bit both;
                        wv   = int'($urandom_range(0, 80)) - 40;
                        both = (k == 0) && ($urandom_range(0, 1) == 1);
                        cfg_write(n, k, wv, 1'b1, both);
                    end
                    if ($urandom_range(0, 1) == 1)
                        cfg_write(n, 0, int'($urandom_range(0, 255)) - 128, 1'b0, 1'b1);
                end
            end
            for (int k = 0; k < NI; k++) x_v[k] = int'($urandom_range(0, 80)) - 40;
            for (int n = 0; n < NN; n++) exp_lane[n] = ref_lane(n);
            send_vector(2);
            expect_result($sformatf("rand%0d", v), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_layer.md
NEURON_LAYER -- requirements
Module: neuron_layer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of parallel neurons sharing one input stream.
REQ-002 SHALL have parameter NUM_INPUTS, default 16: elements per input vector and weights per neuron.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: signed fixed-point width of inputs, weights, biases and outputs.
REQ-004 SHALL have parameter INT_WIDTH, default 4: integer bits including sign; FRAC = DATA_WIDTH-INT_WIDTH.
REQ-005 SHALL have ports, one clock, reset asynchronous active-low:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_data  in  DATA_WIDTH  input element, signed
- in_valid  in  1  element offered
- in_ready  out  1  element accepted when in_valid && in_ready
- cfg_we  in  1  weight write strobe
- cfg_bias_we  in  1  bias write strobe
- cfg_neuron  in  max(1,clog2(NUM_NEURONS))  target neuron
- cfg_addr  in  max(1,clog2(NUM_INPUTS))  weight index
- cfg_data  in  DATA_WIDTH  weight/bias value
- out_data  out  NUM_NEURONS*DATA_WIDTH  neuron n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result

Function
REQ-006 SHALL run FSM IDLE -> ACCUM -> DRAIN -> ACT -> DONE -> IDLE.
REQ-007 IDLE/ACCUM: in_ready=1; each accepted element k (0..NUM_INPUTS-1) multiplies by weight[n][k] in every neuron, product registered.
REQ-008 IDLE: first accepted element moves to ACCUM; accepting element NUM_INPUTS-1 moves to DRAIN; cycles without in_valid hold state and count.
REQ-009 DRAIN, ACT, DONE: in_ready=0.
REQ-010 DRAIN: final product added to accumulator; next cycle ACT.
REQ-011 ACT: acc + (bias<<FRAC), arithmetic shift right FRAC (truncate toward -inf), saturate to DATA_WIDTH signed, activation applied, registered into out_data; next DONE.
REQ-012 Accumulator width = 2*DATA_WIDTH + clog2(NUM_INPUTS) + 1; no internal overflow.
REQ-013 DONE: out_valid=1, out_data stable until out_valid && out_ready; then IDLE with accumulators and count cleared.
REQ-014 Latency: last element accepted cycle T -> out_valid high cycle T+3.
REQ-015 cfg_we/cfg_bias_we act only in IDLE (write at clock edge); ignored in other states; cfg_neuron >= NUM_NEURONS or cfg_addr >= NUM_INPUTS ignored; both strobes together write both.
REQ-016 NUM_INPUTS=1: accepting the only element goes IDLE -> DRAIN directly.

Reset
REQ-017 reset low: state IDLE, count 0, accumulators 0, product regs 0, out_data 0, out_valid 0, in_ready 1 once released.
REQ-018 Reset mid-operation aborts the vector; weights and biases SHALL NOT be reset and are retained.

Configuration
REQ-019 Macro NN_RELU_EN defined: activation = ReLU (negative saturated result -> 0).
REQ-020 NN_RELU_EN undefined: activation = identity; signed saturated result output.

Structure
REQ-021 Package nn_pkg SHALL hold state enum, fixed-point width helpers and the saturation function.
REQ-022 Sub-module neuron_mac SHALL hold one neuron's weight store, bias, product reg, accumulator and activation; instantiated NUM_NEURONS times.

Verification (NUM_NEURONS=4, NUM_INPUTS=4, DATA_WIDTH=8, INT_WIDTH=4; 1.0=0x10)
REQ-023 All weights 0x10, bias 0, inputs 4x0x10 -> each lane 0x40, out_valid at T+3.
REQ-024 Weights 0xF0, bias 0, inputs 4x0x10 -> 0x00 with NN_RELU_EN, 0xC0 without.
REQ-025 Weights 0x70, inputs 4x0x70 -> all lanes 0x7F (positive saturation); bias 0x10 lane 2 only, weights 0x10, inputs 0x10 -> lane2 0x50, others 0x40.
REQ-026 out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-027 reset low after 2 elements accepted -> out_valid 0, out_data 0; weights retained; next full vector gives REQ-023 result.
REQ-028 cfg_we weight 0x00 during ACCUM -> ignored; result unchanged 0x40.
